uart_frame_tx: RTL and testbench
================================

UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, clock cycles per UART bit (50 MHz / 9600 baud).
REQ-002 SHALL have port clock  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to transmit one two-byte response frame; level, sampled only in IDLE.
REQ-005 SHALL have port byte_one  input  8  first byte sent (response command).
REQ-006 SHALL have port byte_two  input  8  second byte sent (response value).
REQ-007 SHALL have port busy  output  1  high while a frame is in progress (all states except IDLE).
REQ-008 SHALL have port tx  output  1  serial line to PC, registered, idle-high.
REQ-009 SHALL have port done  output  1  one-cycle pulse after the second stop bit completes.

Function
REQ-010 SHALL use format 8N1: start bit 0, 8 data bits LSB first, one stop bit 1, each held exactly CLKS_PER_BIT cycles.
REQ-011 SHALL implement states IDLE, START_BIT, DATA_BITS, STOP_BIT, DONE.
REQ-012 IDLE: tx=1, busy=0; on edge with start=1, SHALL latch byte_one and byte_two into an internal 16-bit shift register, clear byte index, go to START_BIT.
REQ-013 tx SHALL go low on the first cycle after the accepting edge (latency 1 cycle start->line).
REQ-014 START_BIT -> DATA_BITS after CLKS_PER_BIT cycles; DATA_BITS -> STOP_BIT after 8 bit periods; 3-bit bit counter wraps 7->0 on exit.
REQ-015 STOP_BIT end: if byte index=0, set index=1 and go to START_BIT with byte_two (no idle gap); if index=1, go to DONE.
REQ-016 DONE SHALL last exactly one cycle with done=1, tx=1, busy=1, then return to IDLE.
REQ-017 A frame SHALL occupy 20*CLKS_PER_BIT cycles of line time plus one DONE cycle.
REQ-018 byte_one/byte_two changes after acceptance SHALL NOT affect the frame in progress.
REQ-019 start asserted while busy=1 SHALL be ignored; no queuing.
REQ-020 start held high continuously SHALL start a new frame on the first IDLE cycle after DONE (back-to-back frames, one idle-high cycle between).
REQ-021 Baud counter SHALL count 0..CLKS_PER_BIT-1 and reload at 0 on each bit boundary; width $clog2(CLKS_PER_BIT).

Reset
REQ-022 reset low SHALL immediately force state=IDLE, tx=1, busy=0, done=0, counters and shift register to 0, including mid-frame.
REQ-023 After reset release, the first start SHALL be accepted no earlier than the first rising edge with reset high.

Structure
REQ-024 CLKS_PER_BIT default, state encodings (3-bit) and frame length (2 bytes) SHALL live in a shared package used by the receiver and transmitter.
REQ-025 A sub-module baud_tick_gen (counter producing a one-cycle tick every CLKS_PER_BIT cycles, cleared on frame start) SHALL be used; no other sub-modules.
REQ-026 All outputs SHALL be driven from registers; no combinational path from inputs to tx.

Verification (CLKS_PER_BIT=4 in bench)
REQ-027 byte_one=8'hA5, byte_two=8'h3C, start pulse 1 cycle -> tx sequence 0,1,0,1,0,0,1,0,1,1 then 0,0,0,1,1,1,1,0,0,1, each bit 4 cycles; done pulse at cycle 81 after acceptance.
REQ-028 start re-asserted at cycle 20 of a frame with byte_one=8'hFF -> ignored; line carries original bytes only, busy stays high.
REQ-029 reset low during DATA_BITS of byte_two -> tx=1, busy=0 in same cycle (asynchronous); no done pulse; next start sends a full fresh frame.
REQ-030 start held high, bytes 8'h00/8'hFF -> two complete frames, exactly one idle-high cycle between the first done and the next start bit.
REQ-031 byte_one changed to 8'h00 one cycle after acceptance of 8'h81 -> line still carries 8'h81.

Source files
------------

// File: rtl/uart_frame_tx_pkg.sv
// Shared definitions for the UART response-frame transmitter and receiver.
// Holds the default bit period, the 3-bit FSM state encoding, the frame
// geometry (two bytes of 8N1), and the byte-pair payload layout.
package uart_frame_tx_pkg;

   // 50 MHz system clock at 9600 baud
   localparam int unsigned CLKS_PER_BIT_DEFAULT = 5208;

   localparam int unsigned BITS_PER_BYTE = 8;
   localparam int unsigned FRAME_BYTES   = 2;
   localparam int unsigned FRAME_W       = FRAME_BYTES * BITS_PER_BYTE;
   localparam int unsigned BIT_CNT_W     = 3;
   localparam int unsigned BYTE_IDX_W    = 1;

   localparam logic [BYTE_IDX_W-1:0] LAST_BYTE_IDX = BYTE_IDX_W'(FRAME_BYTES - 1);
   localparam logic [BIT_CNT_W-1:0]  LAST_BIT_IDX  = BIT_CNT_W'(BITS_PER_BYTE - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START_BIT = 3'd1,
      DATA_BITS = 3'd2,
      STOP_BIT  = 3'd3,
      DONE      = 3'd4
   } uartState_t;

   // First byte sits in the low half so a right shift sends it first, LSB first
   typedef struct packed {
      logic [BITS_PER_BYTE-1:0] byteTwo;
      logic [BITS_PER_BYTE-1:0] byteOne;
   } framePayload_t;

   // Baud counter width; a one-cycle bit period still needs a 1-bit counter
   function automatic int unsigned baudCntWidth(input int unsigned clksPerBit);
      return (clksPerBit > 1) ? $clog2(clksPerBit) : 1;
   endfunction

   function automatic framePayload_t packFrame(input logic [BITS_PER_BYTE-1:0] first,
                                               input logic [BITS_PER_BYTE-1:0] second);
      framePayload_t p;
      p.byteOne = first;
      p.byteTwo = second;
      return p;
   endfunction

endpackage

// File: rtl/uart_frame_tx_baud_tick_gen.sv
// Bit-period timer for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each
// bit period; a synchronous clear realigns the count at frame start.
//   clock   in   system clock
//   reset   in   asynchronous active-low reset
//   clear   in   force count to 0 on the next edge (frame accepted)
//   enable  in   count while a bit is on the line
//   tick_c  out  combinational: high during the final cycle of a bit period
module baud_tick_gen
   import uart_frame_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick_c
);

   localparam int unsigned      CNT_W    = baudCntWidth(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] count;

   // Period counter, reloads at 0 on every bit boundary
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         if (count == CNT_LAST) begin
            count <= '0;
         end else begin
            count <= count + CNT_W'(1);
         end
      end
   end

   assign tick_c = enable && (count == CNT_LAST);

endmodule

// File: rtl/uart_frame_tx.sv
// Two-byte response-frame UART transmitter (8N1, LSB first).
// On an accepted start the command and value bytes are captured, then sent
// back to back as two 8N1 characters followed by a single-cycle done pulse.
//   clock     in   system clock, rising-edge active
//   reset     in   asynchronous active-low reset
//   start     in   level request, only looked at while idle
//   byte_one  in   [7:0] first byte on the line (response command)
//   byte_two  in   [7:0] second byte on the line (response value)
//   busy      out  registered, high in every state except IDLE
//   tx        out  registered serial line, idle high
//   done      out  registered one-cycle pulse after the second stop bit
module uart_frame_tx
   import uart_frame_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] byte_one,
   input  logic [7:0] byte_two,
   output logic       busy,
   output logic       tx,
   output logic       done
);

   uartState_t             state, nextState;
   logic [FRAME_W-1:0]     shiftReg, nextShift;
   logic [BIT_CNT_W-1:0]   bitCnt, nextBitCnt;
   logic [BYTE_IDX_W-1:0]  byteIdx, nextByteIdx;
   logic                   nextTx;
   logic                   nextBusy;
   logic                   nextDone;
   logic                   frameStart;
   logic                   baudEnable;
   logic                   bitTick;
   framePayload_t          payload;

   assign payload    = packFrame(byte_one, byte_two);
   assign frameStart = (state == IDLE) && start;
   assign baudEnable = (state == START_BIT) || (state == DATA_BITS) || (state == STOP_BIT);

   // Bit-period timing, realigned on the accepting edge
   baud_tick_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baudTickGen (
      .clock  (clock),
      .reset  (reset),
      .clear  (frameStart),
      .enable (baudEnable),
      .tick_c (bitTick)
   );

   // State, datapath and output registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         shiftReg <= '0;
         bitCnt   <= '0;
         byteIdx  <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= nextState;
         shiftReg <= nextShift;
         bitCnt   <= nextBitCnt;
         byteIdx  <= nextByteIdx;
         tx       <= nextTx;
         busy     <= nextBusy;
         done     <= nextDone;
      end
   end

   // Next state; tx/busy/done are computed for the state being entered so the
   // registered outputs line up with it without an extra cycle of lag
   always_comb begin
      nextState   = state;
      nextShift   = shiftReg;
      nextBitCnt  = bitCnt;
      nextByteIdx = byteIdx;
      nextTx      = tx;
      nextDone    = 1'b0;

      case (state)
         IDLE: begin
            nextTx = 1'b1;
            if (start) begin
               nextState   = START_BIT;
               nextShift   = payload;
               nextBitCnt  = '0;
               nextByteIdx = '0;
               nextTx      = 1'b0;
            end
         end

         START_BIT: begin
            if (bitTick) begin
               nextState = DATA_BITS;
               nextTx    = shiftReg[0];
            end
         end

         DATA_BITS: begin
            // Shift on every data boundary, including the last, so the next
            // byte is already in the low bits when its start bit ends
            if (bitTick) begin
               nextShift  = shiftReg >> 1;
               nextBitCnt = bitCnt + BIT_CNT_W'(1);
               if (bitCnt == LAST_BIT_IDX) begin
                  nextState = STOP_BIT;
                  nextTx    = 1'b1;
               end else begin
                  nextTx = shiftReg[1];
               end
            end
         end

         STOP_BIT: begin
            if (bitTick) begin
               if (byteIdx == LAST_BYTE_IDX) begin
                  nextState = DONE;
                  nextTx    = 1'b1;
                  nextDone  = 1'b1;
               end else begin
                  nextState   = START_BIT;
                  nextByteIdx = byteIdx + BYTE_IDX_W'(1);
                  nextTx      = 1'b0;
               end
            end
         end

         DONE: begin
            nextState = IDLE;
            nextTx    = 1'b1;
         end

         default: begin
            nextState = IDLE;
            nextTx    = 1'b1;
         end
      endcase

      nextBusy = (nextState != IDLE);
   end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx with a 4-cycle bit period.
// Stimulus pushes the byte pair of every frame it issues; an independent
// monitor records the line from the first busy cycle until done, then pops
// the expectation and compares against an ideal 8N1 waveform.
module tb_uart_frame_tx;

   localparam int CPB  = 4;
   localparam int LINE = 20 * CPB;

   typedef struct {
      logic [7:0] b1;
      logic [7:0] b2;
      int         gap;   // required idle cycles after the previous done, -1 = don't care
   } exp_t;

   logic       clock;
   logic       reset;
   logic       start;
   logic [7:0] byte_one;
   logic [7:0] byte_two;
   logic       busy;
   logic       tx;
   logic       done;

   exp_t expQ[$];
   int   checks   = 0;
   int   passes   = 0;
   int   doneSeen = 0;
   int   expTotal = 0;

   uart_frame_tx #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .byte_one (byte_one),
      .byte_two (byte_two),
      .busy     (busy),
      .tx       (tx),
      .done     (done)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string name, input int got, input int expv);
      checks++;
      if (got == expv) passes++;
      else $display("FAIL %s: got %0d, required %0d", name, got, expv);
   endtask

   task automatic checkWave(input logic [LINE-1:0] got, input logic [LINE-1:0] expv);
      checks++;
      if (got === expv) passes++;
      else $display("FAIL line waveform: got %h, required %h", got, expv);
   endtask

   // Ideal line: start 0, 8 data bits LSB first, stop 1, per byte; each bit CPB cycles
   function automatic logic [LINE-1:0] expectWave(input logic [7:0] b1, input logic [7:0] b2);
      logic [19:0]     seq;
      logic [LINE-1:0] w;
      seq = {1'b1, b2, 1'b0, 1'b1, b1, 1'b0};
      for (int i = 0; i < LINE; i++) w[i] = seq[i / CPB];
      return w;
   endfunction

   // Monitor
   initial begin
      bit              inFrame;
      bit              haveExp;
      int              sampleIdx;
      int              idleCnt;
      int              busyOk;
      int              idleTxOk;
      exp_t            cur;
      logic [LINE-1:0] capt;
      inFrame  = 0;
      haveExp  = 0;
      idleCnt  = 0;
      idleTxOk = 1;
      busyOk   = 1;
      capt     = '0;
      sampleIdx = 0;
      forever begin
         @(negedge clock);
         if (!reset) begin
            inFrame  = 0;
            idleCnt  = 0;
            idleTxOk = 1;
         end else if (!inFrame) begin
            if (busy) begin
               inFrame   = 1;
               sampleIdx = 1;
               busyOk    = 1;
               capt      = '0;
               capt[0]   = tx;
               if (expQ.size() == 0) begin
                  haveExp = 0;
                  check("unexpected frame", 1, 0);
               end else begin
                  cur     = expQ.pop_front();
                  haveExp = 1;
                  if (cur.gap >= 0) check("idle gap before frame", idleCnt, cur.gap);
                  check("idle line high", idleTxOk, 1);
               end
            end else begin
               idleCnt++;
               if (tx !== 1'b1) idleTxOk = 0;
               if (done !== 1'b0) check("spurious done", int'(done), 0);
            end
         end else begin
            sampleIdx++;
            if (busy !== 1'b1) busyOk = 0;
            if (done === 1'b1) begin
               doneSeen++;
               if (haveExp) begin
                  check("done latency", sampleIdx, LINE + 1);
                  checkWave(capt, expectWave(cur.b1, cur.b2));
                  check("busy held through frame", busyOk, 1);
               end
               inFrame  = 0;
               idleCnt  = 0;
               idleTxOk = 1;
            end else if (sampleIdx <= LINE) begin
               capt[sampleIdx-1] = tx;
            end else if (sampleIdx > LINE + 8) begin
               check("frame overrun", sampleIdx, LINE + 1);
               inFrame = 0;
            end
         end
      end
   end

   task automatic waitIdle();
      int budget = 400;
      do begin
         @(negedge clock);
         budget--;
      end while (busy !== 1'b0 && budget > 0);
      if (busy !== 1'b0) check("idle wait timeout", 0, 1);
   endtask

   task automatic waitDone();
      int budget = 400;
      do begin
         @(negedge clock);
         budget--;
      end while (done !== 1'b1 && budget > 0);
      if (done !== 1'b1) check("done wait timeout", 0, 1);
   endtask

   task automatic pushExp(input logic [7:0] b1, input logic [7:0] b2, input int gap);
      exp_t e;
      e.b1  = b1;
      e.b2  = b2;
      e.gap = gap;
      expQ.push_back(e);
      expTotal++;
   endtask

   // One frame: 1-cycle start pulse, optional byte_one change one cycle after
   // acceptance, optional start re-assertion while busy
   task automatic sendFrame(input logic [7:0] b1, input logic [7:0] b2,
                            input bit change, input logic [7:0] nb1, input int pokeAt);
      waitIdle();
      byte_one = b1;
      byte_two = b2;
      start    = 1'b1;
      pushExp(b1, b2, -1);
      @(negedge clock);
      start = 1'b0;
      if (change) byte_one = nb1;
      if (pokeAt > 0) begin
         repeat (pokeAt - 1) @(negedge clock);
         byte_one = 8'hFF;
         byte_two = 8'($urandom);
         start    = 1'b1;
         repeat (3) @(negedge clock);
         start = 1'b0;
      end
      waitDone();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog expired");
   end

   // Stimulus
   initial begin
      reset    = 1'b0;
      start    = 1'b1;
      byte_one = 8'hA5;
      byte_two = 8'h3C;
      repeat (3) @(negedge clock);
      check("reset tx", int'(tx), 1);
      check("reset busy with start held", int'(busy), 0);
      check("reset done", int'(done), 0);

      // First accept on the first edge after release; A5/3C reference frame
      pushExp(8'hA5, 8'h3C, -1);
      reset = 1'b1;
      @(negedge clock);
      start = 1'b0;
      waitDone();

      // Input change after acceptance has no effect
      sendFrame(8'h81, 8'h42, 1'b1, 8'h00, 0);

      // Start re-asserted at cycle 20 with FF is ignored
      sendFrame(8'h5A, 8'hC3, 1'b0, 8'h00, 20);

      // Start held high: two frames, exactly one idle cycle between them
      waitIdle();
      byte_one = 8'h00;
      byte_two = 8'hFF;
      start    = 1'b1;
      pushExp(8'h00, 8'hFF, -1);
      pushExp(8'h00, 8'hFF, 1);
      waitDone();
      waitDone();
      start = 1'b0;

      // Reset during the second byte's data bits aborts the frame at once
      waitIdle();
      byte_one = 8'hE7;
      byte_two = 8'h9B;
      start    = 1'b1;
      pushExp(8'hE7, 8'h9B, -1);
      @(negedge clock);
      start = 1'b0;
      repeat (54) @(posedge clock);
      #1;
      expQ.delete();
      expTotal--;
      reset = 1'b0;
      #1;
      check("async reset tx", int'(tx), 1);
      check("async reset busy", int'(busy), 0);
      check("async reset done", int'(done), 0);
      repeat (3) @(negedge clock);
      reset = 1'b1;

      // Full fresh frame after the abort
      sendFrame(8'h6D, 8'hB2, 1'b0, 8'h00, 0);

      // Randomized frames
      for (int n = 0; n < 8; n++) begin
         logic [7:0] r1, r2, rn;
         bit         chg;
         int         poke;
         r1   = 8'($urandom);
         r2   = 8'($urandom);
         rn   = 8'($urandom);
         chg  = 1'($urandom);
         poke = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 70)) : 0;
         sendFrame(r1, r2, chg, rn, poke);
      end

      repeat (10) @(negedge clock);
      check("frames completed", doneSeen, expTotal);
      check("scoreboard drained", expQ.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
